// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the I-cache, D-cache and memory-bus signals of the
// line-refill / write-back arbiter. "master" is the arbiter's own view and
// "slave" is the view of the surrounding caches and memory.
interface mem_arbiter_if #(
  parameter int LINE_WORDS = 4
);
  localparam int WIDX = $clog2(LINE_WORDS);

  // I-cache side
  logic            i_req;
  logic [31:0]     i_addr;
  logic [31:0]     i_rdata;
  logic            i_rvalid;
  logic            i_done;

  // D-cache side
  logic            d_req;
  logic            d_we;
  logic [31:0]     d_addr;
  logic [31:0]     d_wdata;
  logic [WIDX-1:0] d_widx;
  logic [31:0]     d_rdata;
  logic            d_rvalid;
  logic            d_done;

  // Shared memory bus
  logic            mbus_req;
  logic            mbus_we;
  logic [31:0]     mbus_addr;
  logic [31:0]     mbus_wdata;
  logic [31:0]     mbus_rdata;
  logic            mbus_ack;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mbus_rdata, mbus_ack,
    output i_rdata, i_rvalid, i_done, d_widx, d_rdata, d_rvalid, d_done,
           mbus_req, mbus_we, mbus_addr, mbus_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mbus_rdata, mbus_ack,
    input  i_rdata, i_rvalid, i_done, d_widx, d_rdata, d_rvalid, d_done,
           mbus_req, mbus_we, mbus_addr, mbus_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single memory port to either the I-cache refill path
// or the D-cache refill/write-back path and sequences a LINE_WORDS-word burst.
// Optional build macro ARB_RR_EN: round-robin on contention (default: D wins).
module mem_arbiter #(
  parameter int LINE_WORDS = 4
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.master bus
);
  localparam int              WIDX      = $clog2(LINE_WORDS);
  localparam logic [WIDX-1:0] LAST_IDX  = WIDX'(LINE_WORDS - 1);
  // Clears the word-in-line and byte-in-word bits of a byte address.
  localparam logic [31:0]     LINE_MASK = ~32'(LINE_WORDS * 4 - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2
  } state_t;

  state_t          state_reg;
  logic [WIDX-1:0] cnt_reg;
  logic [31:0]     base_reg;
  logic            we_reg;

  logic            grant_d;
  logic            xfer;
  logic            beat;
  logic            last_beat;

`ifdef ARB_RR_EN
  // 1 = the most recent grant went to the I side, so D wins the next tie.
  logic            last_i_reg;
  assign grant_d = bus.d_req && (!bus.i_req || last_i_reg);
`else
  assign grant_d = bus.d_req;
`endif

  assign xfer      = (state_reg != IDLE);
  assign beat      = xfer && bus.mbus_ack;
  assign last_beat = beat && (cnt_reg == LAST_IDX);

  // Burst sequencer: grant in IDLE, step the word counter on every ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      base_reg   <= '0;
      we_reg     <= 1'b0;
`ifdef ARB_RR_EN
      last_i_reg <= 1'b1;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (grant_d) begin
            state_reg  <= D_XFER;
            base_reg   <= bus.d_addr & LINE_MASK;
            we_reg     <= bus.d_we;
`ifdef ARB_RR_EN
            last_i_reg <= 1'b0;
`endif
          end else if (bus.i_req) begin
            state_reg  <= I_XFER;
            base_reg   <= bus.i_addr & LINE_MASK;
            we_reg     <= 1'b0;
`ifdef ARB_RR_EN
            last_i_reg <= 1'b1;
`endif
          end
        end
        default: begin
          if (beat) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (last_beat) begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
            end
          end
        end
      endcase
    end
  end

  // Bus and per-requester outputs decoded from the registered burst state.
  always_comb begin
    bus.mbus_req   = xfer;
    bus.mbus_we    = 1'b0;
    bus.mbus_addr  = 32'd0;
    bus.mbus_wdata = 32'd0;
    bus.d_widx     = '0;
    bus.i_rdata    = 32'd0;
    bus.i_rvalid   = 1'b0;
    bus.i_done     = 1'b0;
    bus.d_rdata    = 32'd0;
    bus.d_rvalid   = 1'b0;
    bus.d_done     = 1'b0;
    if (xfer) begin
      bus.mbus_we   = we_reg;
      bus.mbus_addr = base_reg + {{(30 - WIDX){1'b0}}, cnt_reg, 2'b00};
    end
    if (state_reg == I_XFER) begin
      bus.i_rvalid = beat;
      bus.i_rdata  = beat ? bus.mbus_rdata : 32'd0;
      bus.i_done   = last_beat;
    end
    if (state_reg == D_XFER) begin
      bus.d_widx     = cnt_reg;
      bus.mbus_wdata = bus.d_wdata;
      bus.d_rvalid   = beat && !we_reg;
      bus.d_rdata    = (beat && !we_reg) ? bus.mbus_rdata : 32'd0;
      bus.d_done     = last_beat;
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port main-memory arbiter between the I-cache refill path and the D-cache refill/write-back path of the pipelined MIPS32 core. Grants the shared memory bus to one requester at a time and sequences a full-line burst of `LINE_WORDS` word transfers. Forwards per-word data and a completion pulse to the owner. Sits between both caches and external memory; the caches' ready signals, which freeze the pipeline registers, depend on its `*_done` pulses.

## Interface
- `LINE_WORDS`, 4: words per cache line; power of two, ≥2. `WIDX = log2(LINE_WORDS)`.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  1  I-cache line read request; held until `i_done`.
- `i_addr`  in  32  I-side byte address; stable while `i_req`.
- `i_rdata`  out  32  read word to I-cache.
- `i_rvalid`  out  1  `i_rdata` valid this cycle.
- `i_done`  out  1  final word of I burst this cycle.
- `d_req`  in  1  D-cache line request; held until `d_done`.
- `d_we`  in  1  1 = line write-back, 0 = line refill; stable while `d_req`.
- `d_addr`  in  32  D-side byte address; stable while `d_req`.
- `d_wdata`  in  32  write word selected by `d_widx`.
- `d_widx`  out  WIDX  word index the D-cache must drive on `d_wdata`.
- `d_rdata`  out  32  read word to D-cache.
- `d_rvalid`  out  1  `d_rdata` valid (reads only).
- `d_done`  out  1  final word of D burst this cycle.
- `mbus_req`  out  1  word transfer request to memory.
- `mbus_we`  out  1  write strobe.
- `mbus_addr`  out  32  word-aligned byte address.
- `mbus_wdata`  out  32  write data.
- `mbus_rdata`  in  32  read data, valid with `mbus_ack`.
- `mbus_ack`  in  1  current word completed this cycle.

## Operation
- States: IDLE, I_XFER, D_XFER. Registers: state, word counter `cnt` (WIDX bits), latched base address, latched `we`, owner.
- IDLE: if any request is pending, grant by priority. Latch base = address with bits [WIDX+1:0] forced to 0, latch `we` (forced 0 for I), clear `cnt`, and enter the owner's XFER state. No request: stay.
- Priority: D over I when both are pending (see Configuration).
- XFER: `mbus_req`=1. `mbus_addr` = base + (`cnt` << 2). `mbus_we` = latched `we`. `mbus_wdata` = `d_wdata`, which is 0 in I_XFER. `d_widx` = `cnt` in D_XFER, 0 otherwise.
- `mbus_ack`=0: hold all registers; outputs stay stable.
- `mbus_ack`=1: owner's `*_rvalid`=1 for reads, with `*_rdata` = `mbus_rdata` (combinational). `cnt` increments.
- `mbus_ack`=1 with `cnt`==LINE_WORDS-1: owner's `*_done`=1 that cycle. State → IDLE, `cnt` wraps to 0.
- Requester drops `*_req` at the edge where it samples `*_done`. A request still high in the following IDLE cycle is a new request.
- Write-back: `d_rvalid` is never asserted; only `d_done`.
- Non-owner outputs (`*_rvalid`, `*_done`) are always 0. `*_rdata` are 0 outside their owner's ack cycles.

## Timing
- Reset values: state IDLE, `cnt` 0, all outputs 0, round-robin flag favours D.
- Request seen in IDLE at edge N → `mbus_req` high in cycle N+1.
- Minimum burst with ack every cycle: 1 IDLE cycle + LINE_WORDS transfer cycles. Back-to-back bursts are separated by exactly one IDLE cycle.
- `mbus_ack` is ignored outside XFER.
- Reset asserted mid-burst: IDLE at next edge, `mbus_req` low, no `*_done`, partial data abandoned. A later request restarts at word 0.

## Configuration
- `ARB_RR_EN` undefined: fixed priority; D always wins contention in IDLE.
- `ARB_RR_EN` defined: 1-bit last-grant flag, updated on every grant, reset to "I last". On contention, the requester not granted last wins. Uncontended grants behave identically in both builds.

## Test plan
- Reset: assert `reset` 2 cycles with `i_req`=`d_req`=1 → all outputs 0, `mbus_req` 0 during reset.
- I refill, `i_addr`=0x0000_010C, ack every cycle, rdata 0x10..0x13 → `mbus_addr` 0x100, 0x104, 0x108, 0x10C in cycles 1–4. `i_rvalid` in cycles 1–4; `i_done` in cycle 4 only.
- D write-back at 0x200 with 2 ack-low cycles before each ack → address and `d_widx` hold, `d_widx` steps 0,1,2,3. `mbus_we`=1 and `mbus_wdata` follows `d_wdata`; `d_rvalid` never set.
- Contention: `i_req` and `d_req` rise together → D served first, one IDLE cycle, then I. With `ARB_RR_EN`, repeat contention → I served first.
- Reset mid-burst after 2 acks → next cycle IDLE, `mbus_req` 0, no done. Re-request at 0x300 → `mbus_addr` starts at 0x300.
